// File: rtl/intc_ext_pkg.sv
// Shared definitions for the intc_ext interrupt controller: CSR register
// offsets within a bank, bank geometry and a bank-count helper.
package intc_ext_pkg;

    localparam int unsigned BANK_WIDTH  = 8;
    localparam logic [4:0]  BANK_STRIDE = 5'd4;

    typedef enum logic [1:0] {
        REG_IE   = 2'd0,
        REG_IP   = 2'd1,
        REG_EDGE = 2'd2,
        REG_POL  = 2'd3
    } reg_ofs_e;

    localparam logic [4:0] OFS_IE   = {3'b000, REG_IE};
    localparam logic [4:0] OFS_IP   = {3'b000, REG_IP};
    localparam logic [4:0] OFS_EDGE = {3'b000, REG_EDGE};
    localparam logic [4:0] OFS_POL  = {3'b000, REG_POL};

    function automatic int unsigned num_banks(input int unsigned n);
        return (n + BANK_WIDTH - 1) / BANK_WIDTH;
    endfunction

endpackage

// File: rtl/intc_ext_sync_ff.sv
// sync_ff: per-bit flip-flop chain for bringing asynchronous inputs into the
// clk domain. Synchronous active-high reset to 0; STAGES=0 is a plain wire.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign q_o = d_i;
    end else begin : g_chain
        logic [WIDTH-1:0] chain_q [STAGES];

        // shift the input through the chain; reset flushes every stage
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(STAGES); i++) begin
                    chain_q[i] <= '0;
                end
            end else begin
                chain_q[0] <= d_i;
                for (int i = 1; i < int'(STAGES); i++) begin
                    chain_q[i] <= chain_q[i-1];
                end
            end
        end

        assign q_o = chain_q[STAGES-1];
    end

endmodule

// File: rtl/intc_ext.sv
// intc_ext: interrupt controller with up to 16 sources in banks of 8.
// Per-source enable, pending (write-1-to-clear), edge/level mode and
// polarity. The combined irq is either a one-cycle pulse per newly pending
// enabled source or a registered level of any enabled pending source.
module intc_ext
    import intc_ext_pkg::*;
#(
    parameter logic [4:0]  BASE_ADDR   = 5'h0,
    parameter int unsigned NUM_INTS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          IRQ_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] irqs_in,
    output logic                irq
);

    localparam int unsigned NB = num_banks(NUM_INTS);
    localparam int unsigned W  = NB * BANK_WIDTH;
    // bits at or above NUM_INTS never hold state
    localparam logic [W-1:0] VALID = W'((64'd1 << NUM_INTS) - 64'd1);

    logic [NUM_INTS-1:0] s_sync;
    logic [W-1:0]        s, sd_q, act, ev;
    logic [W-1:0]        ie_f, ip_f, edge_f, pol_f, ie_d_f, ip_d_f;

    logic [7:0] ie_q   [NB];
    logic [7:0] ip_q   [NB];
    logic [7:0] edge_q [NB];
    logic [7:0] pol_q  [NB];
    logic [7:0] ie_d   [NB];
    logic [7:0] ip_d   [NB];
    logic [7:0] edge_d [NB];
    logic [7:0] pol_d  [NB];
    logic [7:0] rd_bank[NB];
    logic [NB-1:0] ie_wr;

    logic irq_q, irq_d;

    sync_ff #(
        .WIDTH (NUM_INTS),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(irqs_in),
        .q_o(s_sync)
    );

    assign s = W'(s_sync);

    // flat bit vectors of the banked registers for the per-source logic
    always_comb begin
        ie_f   = '0;
        ip_f   = '0;
        edge_f = '0;
        pol_f  = '0;
        ie_d_f = '0;
        ip_d_f = '0;
        for (int b = 0; b < int'(NB); b++) begin
            ie_f[b*8 +: 8]   = ie_q[b];
            ip_f[b*8 +: 8]   = ip_q[b];
            edge_f[b*8 +: 8] = edge_q[b];
            pol_f[b*8 +: 8]  = pol_q[b];
            ie_d_f[b*8 +: 8] = ie_d[b];
            ip_d_f[b*8 +: 8] = ip_d[b];
        end
    end

    // Current POL qualifies both the present and the delayed sample, so
    // rewriting POL or EDGE alone can never look like an input transition.
    assign act = s ^ pol_f;
    assign ev  = act & (~edge_f | ~(sd_q ^ pol_f)) & VALID;

    for (genvar b = 0; b < int'(NB); b++) begin : g_bank
        localparam logic [4:0] A     = BASE_ADDR + BANK_STRIDE * 5'(b);
        localparam logic [7:0] BMASK = VALID[b*8 +: 8];

        logic hit_ie, hit_ip, hit_edge, hit_pol;

        assign hit_ie   = csr_we && (csr_a == A + OFS_IE);
        assign hit_ip   = csr_we && (csr_a == A + OFS_IP);
        assign hit_edge = csr_we && (csr_a == A + OFS_EDGE);
        assign hit_pol  = csr_we && (csr_a == A + OFS_POL);

        assign ie_wr[b]  = hit_ie;
        assign ie_d[b]   = hit_ie   ? (csr_di & BMASK) : ie_q[b];
        assign edge_d[b] = hit_edge ? (csr_di & BMASK) : edge_q[b];
        assign pol_d[b]  = hit_pol  ? (csr_di & BMASK) : pol_q[b];
        // a new event outranks a same-cycle clear of the same bit
        assign ip_d[b]   = ((ip_q[b] & ~(hit_ip ? csr_di : 8'h00)) | ev[b*8 +: 8]) & BMASK;

        assign rd_bank[b] = (csr_a == A + OFS_IE)   ? ie_q[b]   :
                            (csr_a == A + OFS_IP)   ? ip_q[b]   :
                            (csr_a == A + OFS_EDGE) ? edge_q[b] :
                            (csr_a == A + OFS_POL)  ? pol_q[b]  : 8'h00;
    end

    // read mux: at most one bank matches, unmapped addresses read 0
    always_comb begin
        csr_do = 8'h00;
        for (int b = 0; b < int'(NB); b++) begin
            csr_do = csr_do | rd_bank[b];
        end
    end

    // irq next value: level of enabled pending, or pulse on new enabled work
    always_comb begin
        irq_d = 1'b0;
        if (IRQ_LEVEL) begin
            irq_d = |(ie_d_f & ip_d_f);
        end else begin
            irq_d = (|(ie_f & ev & ~ip_f)) || ((|ie_wr) && (|(ie_d_f & ip_f)));
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_q  <= '0;
            irq_q <= 1'b0;
            for (int b = 0; b < int'(NB); b++) begin
                ie_q[b]   <= 8'h00;
                ip_q[b]   <= 8'h00;
                edge_q[b] <= 8'h00;
                pol_q[b]  <= 8'h00;
            end
        end else begin
            sd_q  <= s;
            irq_q <= irq_d;
            for (int b = 0; b < int'(NB); b++) begin
                ie_q[b]   <= ie_d[b];
                ip_q[b]   <= ip_d[b];
                edge_q[b] <= edge_d[b];
                pol_q[b]  <= pol_d[b];
            end
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_intc_ext.sv
// Bench for intc_ext: two instances (level and pulse irq) share stimulus.
// A per-source behavioural model predicts CSR reads and irq; expectations
// are queued and compared by independent monitor processes.
`timescale 1ns/1ps
module tb_intc_ext;
    import intc_ext_pkg::*;

    localparam int         NI   = 12;
    localparam int         SYNC = 2;
    localparam int         NBK  = 2;
    localparam logic [4:0] BASE = 5'h08;

    localparam logic [4:0] A_IE0   = BASE + OFS_IE;
    localparam logic [4:0] A_IP0   = BASE + OFS_IP;
    localparam logic [4:0] A_EDGE0 = BASE + OFS_EDGE;
    localparam logic [4:0] A_POL0  = BASE + OFS_POL;
    localparam logic [4:0] A_IE1   = BASE + BANK_STRIDE + OFS_IE;
    localparam logic [4:0] A_IP1   = BASE + BANK_STRIDE + OFS_IP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    csr_a = '0;
    logic [7:0]    csr_di = '0;
    logic          csr_we = 1'b0;
    logic [NI-1:0] irqs_in = '0;
    logic [7:0]    do_l, do_p;
    logic          irq_l, irq_p;

    always #5 clk = ~clk;

    intc_ext #(.BASE_ADDR(BASE), .NUM_INTS(NI), .SYNC_STAGES(SYNC), .IRQ_LEVEL(1'b1)) dut_lvl (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(do_l), .irqs_in(irqs_in), .irq(irq_l)
    );

    intc_ext #(.BASE_ADDR(BASE), .NUM_INTS(NI), .SYNC_STAGES(SYNC), .IRQ_LEVEL(1'b0)) dut_pls (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(do_p), .irqs_in(irqs_in), .irq(irq_p)
    );

    // behavioural model state, one entry per source
    bit            m_ie[NI], m_ip[NI], m_edge[NI], m_pol[NI], m_hist[NI];
    logic [NI-1:0] m_pipe[$];
    bit            m_irq_l, m_irq_p, m_known;

    logic [7:0]    q_do[$];
    logic [1:0]    q_irq[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic [NI-1:0] cur_in = '0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [7:0] model_read(input logic [4:0] a);
        logic [7:0] r;
        int idx, bank, ofs, i;
        r = 8'h00;
        if (int'(a) >= int'(BASE) && int'(a) < int'(BASE) + 4*NBK) begin
            idx  = int'(a) - int'(BASE);
            bank = idx / 4;
            ofs  = idx % 4;
            for (int j = 0; j < 8; j++) begin
                i = bank*8 + j;
                if (i < NI) begin
                    case (ofs)
                        0: r[j] = m_ie[i];
                        1: r[j] = m_ip[i];
                        2: r[j] = m_edge[i];
                        default: r[j] = m_pol[i];
                    endcase
                end
            end
        end
        return r;
    endfunction

    // advance the model by one clock using the inputs presented this cycle
    task automatic model_step();
        bit ev[NI];
        bit old_ip[NI];
        bit act, was, ie_written, any_ie_ip, new_pend;
        logic [NI-1:0] s;
        int idx, bank, ofs, i;
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                m_ie[k] = 0; m_ip[k] = 0; m_edge[k] = 0; m_pol[k] = 0; m_hist[k] = 0;
            end
            m_pipe = {};
            for (int k = 0; k < SYNC; k++) m_pipe.push_back('0);
            m_irq_l = 0;
            m_irq_p = 0;
            m_known = 1;
            return;
        end
        if (!m_known) return;
        s = m_pipe[0];
        new_pend = 0;
        for (int k = 0; k < NI; k++) begin
            act = s[k] ^ m_pol[k];
            was = m_hist[k] ^ m_pol[k];
            ev[k] = m_edge[k] ? (act && !was) : act;
            old_ip[k] = m_ip[k];
            if (m_ie[k] && ev[k] && !m_ip[k]) new_pend = 1;
        end
        ie_written = 0;
        if (csr_we && int'(csr_a) >= int'(BASE) && int'(csr_a) < int'(BASE) + 4*NBK) begin
            idx  = int'(csr_a) - int'(BASE);
            bank = idx / 4;
            ofs  = idx % 4;
            if (ofs == 0) ie_written = 1;
            for (int j = 0; j < 8; j++) begin
                i = bank*8 + j;
                if (i < NI) begin
                    case (ofs)
                        0: m_ie[i] = csr_di[j];
                        1: if (csr_di[j]) m_ip[i] = 0;
                        2: m_edge[i] = csr_di[j];
                        default: m_pol[i] = csr_di[j];
                    endcase
                end
            end
        end
        any_ie_ip = 0;
        m_irq_l = 0;
        for (int k = 0; k < NI; k++) begin
            if (ev[k]) m_ip[k] = 1;
            if (m_ie[k] && old_ip[k]) any_ie_ip = 1;
            if (m_ie[k] && m_ip[k]) m_irq_l = 1;
            m_hist[k] = s[k];
        end
        m_irq_p = new_pend || (ie_written && any_ie_ip);
        void'(m_pipe.pop_front());
        m_pipe.push_back(irqs_in);
    endtask

    task automatic cyc(input logic r, input logic [4:0] a, input logic [7:0] di,
                       input logic we, input logic [NI-1:0] ins);
        @(negedge clk);
        rst = r; csr_a = a; csr_di = di; csr_we = we; irqs_in = ins;
        if (m_known) q_do.push_back(model_read(a));
        @(posedge clk);
        model_step();
        if (m_known) q_irq.push_back({m_irq_l, m_irq_p});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] di);
        cyc(1'b0, a, di, 1'b1, cur_in);
    endtask

    task automatic rd(input logic [4:0] a, input int n);
        repeat (n) cyc(1'b0, a, 8'h00, 1'b0, cur_in);
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(1'b1, A_IP0, 8'hFF, 1'b1, cur_in);
    endtask

    // read-data monitor, samples mid low phase after inputs settle
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (q_do.size() > 0) begin
                e = q_do.pop_front();
                check("csr_do_lvl", do_l, e);
                check("csr_do_pls", do_p, e);
            end
        end
    end

    // irq monitor, samples just after the active edge
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q_irq.size() > 0) begin
                e = q_irq.pop_front();
                check("irq_lvl", {7'b0, irq_l}, {7'b0, e[1]});
                check("irq_pls", {7'b0, irq_p}, {7'b0, e[0]});
            end
        end
    end

    initial begin
        logic          r, we;
        logic [4:0]    a;
        logic [7:0]    di;

        // level source held active, clear while still active
        cur_in = '0;
        do_reset(2);
        rd(A_IE0, 1); rd(A_IP0, 1); rd(A_EDGE0, 1); rd(A_POL0, 1);
        wr(A_IE0, 8'h01);
        cur_in[0] = 1'b1;
        rd(A_IP0, 5);
        wr(A_IP0, 8'h01);
        rd(A_IP0, 3);
        cur_in[0] = 1'b0;
        wr(A_IP0, 8'h01);
        rd(A_IP0, 4);

        // active-low edge: one falling edge, then clear and hold low
        do_reset(1);
        wr(A_EDGE0, 8'h01);
        wr(A_POL0, 8'h01);
        cur_in[0] = 1'b1;
        rd(A_IP0, 4);
        wr(A_IE0, 8'h01);
        cur_in[0] = 1'b0;
        rd(A_IP0, 5);
        wr(A_IP0, 8'h01);
        rd(A_IP0, 4);

        // edge event on bit 3 coinciding with its W1C
        do_reset(1);
        cur_in = '0;
        wr(A_EDGE0, 8'h08);
        wr(A_IE0, 8'h08);
        cur_in[3] = 1'b1;
        rd(A_IP0, 4);
        cur_in[3] = 1'b0;
        rd(A_IP0, 4);
        cur_in[3] = 1'b1;
        rd(A_IP0, 2);
        wr(A_IP0, 8'h08);
        rd(A_IP0, 3);

        // pulse on IE write with an already pending source
        do_reset(1);
        cur_in = '0;
        rd(A_IP0, 1);
        cur_in[2] = 1'b1;
        rd(A_IP0, 5);
        wr(A_IE0, 8'h04);
        rd(A_IE0, 4);
        wr(A_IE0, 8'h04);
        rd(A_IP0, 2);

        // upper bank decode and masking, unmapped writes ignored
        do_reset(1);
        cur_in = '0;
        cur_in[11] = 1'b1;
        rd(A_IP1, 5);
        wr(A_IE1, 8'hFF);
        rd(A_IE1, 2);
        wr(5'h10, 8'hFF);
        wr(5'h07, 8'hFF);
        rd(5'h10, 1); rd(5'h07, 1); rd(5'h0F, 1); rd(5'h00, 1);

        // input high at reset release, POL toggles, reset mid-event
        do_reset(1);
        cur_in = '0;
        cur_in[0] = 1'b1;
        wr(A_EDGE0, 8'h01);
        wr(A_IE0, 8'h01);
        rd(A_IP0, 3);
        wr(A_IP0, 8'h01);
        wr(A_POL0, 8'h01);
        wr(A_POL0, 8'h00);
        wr(A_POL0, 8'h01);
        rd(A_IP0, 4);
        cur_in[0] = 1'b0;
        rd(A_IP0, 2);
        do_reset(1);
        for (int k = 0; k < 8; k++) rd(5'(BASE + k), 1);
        cur_in = '1;
        do_reset(3);
        rd(A_IP0, 4);
        rd(A_IP1, 1);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) cur_in ^= NI'(1 << $urandom_range(0, NI-1));
            r  = ($urandom_range(0, 149) == 0);
            we = ($urandom_range(0, 3) == 0);
            a  = we ? 5'(BASE + 5'($urandom_range(0, 7))) : 5'($urandom_range(0, 31));
            di = 8'($urandom);
            cyc(r, a, di, we, cur_in);
        end

        repeat (3) @(negedge clk);
        n_total++;
        if (q_do.size() == 0 && q_irq.size() == 0) n_pass++;
        else $display("FAIL queues_drained: got %0d/%0d left expected 0/0", q_do.size(), q_irq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
